// File: rtl/dense_layer_mac.sv
// dense_layer_mac: sequential fully-connected layer engine, y[i] = sum_j(x[j]*w[i][j]) + b[i].
// Q8.24 signed fixed point with a single time-shared multiplier; one MAC per cycle,
// one bias/writeback cycle per output element.
// Optional feature macro: DENSE_SAT_EN -- saturate each result to the signed WIDTH range
// (default build wraps to the low WIDTH bits instead).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the start edge
// MAC   | acc += x[j]*w[i][j], one input element per cycle
// BIAS  | y[i] = narrow((acc >>> FRAC) + b[i]); clear acc, advance i
// DONE  | one-cycle done pulse, y_out complete
module dense_layer_mac #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int N_IN  = 3,
    parameter int N_OUT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_IN*WIDTH-1:0]       x_in,
    input  logic [N_OUT*N_IN*WIDTH-1:0] w_in,
    input  logic [N_OUT*WIDTH-1:0]      b_in,
    output logic                        busy,
    output logic                        done,
    output logic [N_OUT*WIDTH-1:0]      y_out
);

    localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1;
    localparam int JW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

    state_t state, state_nxt;

    logic [N_IN*WIDTH-1:0]       x_r;
    logic [N_OUT*N_IN*WIDTH-1:0] w_r;
    logic [N_OUT*WIDTH-1:0]      b_r;
    logic signed [ACC_W-1:0]     acc;
    logic [IW-1:0]               i_cnt;
    logic [JW-1:0]               j_cnt;

    logic signed [WIDTH-1:0]     x_cur;
    logic signed [WIDTH-1:0]     w_cur;
    logic signed [WIDTH-1:0]     b_cur;
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_W-1:0]     prod_ext;
    logic [WIDTH-1:0]            y_new;

    logic j_last;
    logic i_last;

    assign j_last = (j_cnt == J_LAST);
    assign i_last = (i_cnt == I_LAST);

    // Operand select and the shared multiplier.
    always_comb begin
        x_cur    = x_r[j_cnt*WIDTH +: WIDTH];
        w_cur    = w_r[(i_cnt*N_IN + j_cnt)*WIDTH +: WIDTH];
        b_cur    = b_r[i_cnt*WIDTH +: WIDTH];
        prod     = x_cur * w_cur;
        prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    end

`ifdef DENSE_SAT_EN
    logic signed [ACC_W-1:0] r_full;
    logic [ACC_W-WIDTH:0]    r_top;

    // Rescale, add bias, then clamp to the signed WIDTH range.
    always_comb begin
        r_full = (acc >>> FRAC) + {{(ACC_W-WIDTH){b_cur[WIDTH-1]}}, b_cur};
        r_top  = r_full[ACC_W-1:WIDTH-1];
        if ((&r_top) || !(|r_top))
            y_new = r_full[WIDTH-1:0];
        else if (r_full[ACC_W-1])
            y_new = {1'b1, {(WIDTH-1){1'b0}}};
        else
            y_new = {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    // Rescale and add bias; only the low WIDTH bits are kept, so the sum is formed at WIDTH.
    always_comb begin
        y_new = acc[FRAC +: WIDTH] + b_cur;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = MAC;
            MAC:  if (j_last) state_nxt = BIAS;
            BIAS: state_nxt = i_last ? DONE : MAC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand capture, accumulation, counters and result writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r   <= '0;
            w_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            y_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r   <= x_in;
                        w_r   <= w_in;
                        b_r   <= b_in;
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (!j_last)
                        j_cnt <= j_cnt + 1'b1;
                end
                BIAS: begin
                    y_out[i_cnt*WIDTH +: WIDTH] <= y_new;
                    acc   <= '0;
                    j_cnt <= '0;
                    if (!i_last)
                        i_cnt <= i_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Self-checking bench for dense_layer_mac (default 3x3, Q8.24).
// Builds with or without DENSE_SAT_EN; overflow expectations follow the macro.
module tb_dense_layer_mac;

    localparam int W = 32;

    typedef struct {
        logic [95:0]  x;
        logic [287:0] w;
        logic [95:0]  b;
        logic [95:0]  y;
    } vec_t;

`ifdef DENSE_SAT_EN
    localparam logic [31:0] OVF = 32'h7FFFFFFF;
    localparam logic [31:0] UNF = 32'h80000000;
`else
    localparam logic [31:0] OVF = 32'h2C000000;
    localparam logic [31:0] UNF = 32'hD4000000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [95:0]   x_in;
    logic [287:0]  w_in;
    logic [95:0]   b_in;
    logic          busy;
    logic          done;
    logic [95:0]   y_out;

    int n_vec  = 0;
    int n_miss = 0;
    logic [95:0] sb[$];

    dense_layer_mac dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .w_in  (w_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .y_out (y_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] pack3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction

    // Reference: exact wide arithmetic, then shift, bias add and narrowing.
    function automatic logic [95:0] ref_y(input logic [95:0] x, input logic [287:0] w, input logic [95:0] b);
        logic [95:0] y;
        logic signed [31:0]  t;
        logic signed [127:0] s, xe, we, be, r;
        y = '0;
        for (int i = 0; i < 3; i++) begin
            s = '0;
            for (int j = 0; j < 3; j++) begin
                t  = x[j*32 +: 32];
                xe = t;
                t  = w[(i*3+j)*32 +: 32];
                we = t;
                s  = s + xe * we;
            end
            t  = b[i*32 +: 32];
            be = t;
            r  = (s >>> 24) + be;
`ifdef DENSE_SAT_EN
            if (r > 128'sd2147483647)
                r = 128'sd2147483647;
            else if (r < -128'sd2147483648)
                r = -128'sd2147483648;
`endif
            y[i*32 +: 32] = r[31:0];
        end
        return y;
    endfunction

    // Scoreboard: each done pulse retires the oldest expected result vector.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1, expected no pending run");
            end else begin
                logic [95:0] e;
                e = sb.pop_front();
                for (int i = 0; i < 3; i++)
                    chk($sformatf("y[%0d]", i), y_out[i*32 +: 32], e[i*32 +: 32]);
            end
        end
    end

    task automatic launch(input vec_t v);
        x_in  = v.x;
        w_in  = v.w;
        b_in  = v.b;
        start = 1'b1;
        sb.push_back(v.y);
        step();
        start = 1'b0;
    endtask

    // Returns the cycle index (cycle 1 = first cycle after the start edge) where done is seen.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end
    endtask

    vec_t vecs[6];
    vec_t v_b2b;
    int   n, n2, extra;

    initial begin
        // basic
        vecs[0].x = pack3(32'h01000000, 32'h02000000, 32'hFF000000);
        vecs[0].w = {9{32'h00800000}};
        vecs[0].b = pack3(32'h01A1B251, 32'hFCFA3A3D, 32'h00000000);
        vecs[0].y = pack3(32'h02A1B251, 32'hFDFA3A3D, 32'h01000000);
        // overflow
        vecs[1].x = {3{32'h64000000}};
        vecs[1].w = {9{32'h01000000}};
        vecs[1].b = '0;
        vecs[1].y = {3{OVF}};
        // truncation toward -inf
        vecs[2].x = pack3(32'hFFFFFFFF, 32'h0, 32'h0);
        vecs[2].w = 288'(32'h00800000);
        vecs[2].b = '0;
        vecs[2].y = pack3(32'hFFFFFFFF, 32'h0, 32'h0);
        // underflow
        vecs[3].x = {3{32'h9C000000}};
        vecs[3].w = {9{32'h01000000}};
        vecs[3].b = '0;
        vecs[3].y = {3{UNF}};
        // random, small magnitudes (about +-2.0)
        for (int k = 4; k < 6; k++) begin
            for (int j = 0; j < 3; j++) begin
                vecs[k].x[j*32 +: 32] = $urandom_range(32'h03FFFFFF, 0) - 32'h02000000;
                vecs[k].b[j*32 +: 32] = $urandom_range(32'h03FFFFFF, 0) - 32'h02000000;
            end
            for (int j = 0; j < 9; j++)
                vecs[k].w[j*32 +: 32] = $urandom_range(32'h03FFFFFF, 0) - 32'h02000000;
            vecs[k].y = ref_y(vecs[k].x, vecs[k].w, vecs[k].b);
        end
        v_b2b.x = '0;
        v_b2b.w = {9{32'h00800000}};
        v_b2b.b = pack3(32'h01A1B251, 32'hFCFA3A3D, 32'h00000000);
        v_b2b.y = pack3(32'h01A1B251, 32'hFCFA3A3D, 32'h00000000);

        rst = 1'b1; start = 1'b0; x_in = '0; w_in = '0; b_in = '0;
        repeat (3) step();
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_y[%0d]", i), y_out[i*32 +: 32], 32'h0);

        // rst and start together: rst wins
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_start_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // table-driven runs
        for (int k = 0; k < 6; k++) begin
            launch(vecs[k]);
            chk($sformatf("v%0d_busy_c1", k), {31'b0, busy}, 32'd1);
            wait_done(1, n);
            chk($sformatf("v%0d_latency", k), n, 32'd13);
            step();
            chk($sformatf("v%0d_done_once", k), {31'b0, done}, 32'd0);
            chk($sformatf("v%0d_idle", k), {31'b0, busy}, 32'd0);
            chk($sformatf("v%0d_hold_y0", k), y_out[31:0], vecs[k].y[31:0]);
        end

        // back-to-back: start in the IDLE cycle right after done
        launch(vecs[0]);
        wait_done(1, n);
        step();
        launch(v_b2b);
        wait_done(1, n2);
        chk("b2b_gap", 1 + n2, 32'd14);
        step();

        // input isolation: inputs change and start pulses while busy
        launch(vecs[0]);
        repeat (2) step();
        x_in  = vecs[1].x;
        w_in  = vecs[1].w;
        b_in  = vecs[1].b;
        start = 1'b1;
        step();
        start = 1'b0;
        x_in  = vecs[3].x;
        step();
        wait_done(5, n);
        chk("iso_latency", n, 32'd13);
        extra = 0;
        repeat (20) begin
            step();
            if (done) extra++;
        end
        chk("iso_no_second_run", extra, 32'd0);
        chk("iso_idle", {31'b0, busy}, 32'd0);

        // reset in the 5th MAC cycle (cycle 6 after the start edge)
        launch(vecs[1]);
        repeat (5) step();
        chk("midrst_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_y", {31'b0, (y_out == '0)}, 32'd1);
        step();
        launch(vecs[2]);
        wait_done(1, n);
        chk("midrst_rerun_latency", n, 32'd13);
        repeat (3) step();

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dense_layer_mac.md
# dense_layer_mac

Sequential fully-connected layer engine for the GAN datapath. It sits directly downstream of the bias ROM and consumes one layer's bias vector together with an input activation vector and a weight matrix. It computes y[i] = sum_j(x[j]·w[i][j]) + b[i] in Q8.24 fixed point, using a single time-shared multiplier. It is instantiated once per generator/discriminator layer, with N_IN/N_OUT set to that layer's widths.

## Interface
- WIDTH, 32: data word width; all operands are signed two's complement.
- FRAC, 24: fractional bits (Q8.24, 1.0 = 32'h01000000).
- N_IN, 3: input vector length.
- N_OUT, 3: output vector length; matches the bias vector length of the layer.
- clk  in  1  clock; single clock domain; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in  in  N_IN*WIDTH  input vector; element j at [j*WIDTH +: WIDTH].
- w_in  in  N_OUT*N_IN*WIDTH  weights; w[i][j] at [(i*N_IN+j)*WIDTH +: WIDTH].
- b_in  in  N_OUT*WIDTH  bias vector (bias ROM output); b[i] at [i*WIDTH +: WIDTH].
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: y_out is complete.
- y_out  out  N_OUT*WIDTH  result; y[i] at [i*WIDTH +: WIDTH]; registered.

## Operation
- States: IDLE, MAC, BIAS, DONE. Counters: i (output index), j (input index). Accumulator: acc, signed, 2*WIDTH+$clog2(N_IN)+1 bits.
- IDLE: if start=1, latch x_in, w_in, b_in into internal registers, clear acc, set i=0 and j=0, then go to MAC. Otherwise stay in IDLE.
- MAC: acc += x[j]*w[i][j], using the full 2*WIDTH signed product with no rounding. If j==N_IN-1, go to BIAS; otherwise j++.
- BIAS: compute r = (acc >>> FRAC) + sign-extended b[i]. The arithmetic shift truncates toward −inf. Narrow r to WIDTH per Configuration and write it to y[i]. Clear acc and set j=0. If i==N_OUT-1, go to DONE; otherwise i++ and go to MAC.
- DONE: done=1 for this cycle only, then go to IDLE.
- Inputs are captured only at the start cycle. Changes to x_in, w_in or b_in during busy have no effect on the current run.
- start while busy is ignored and is not queued.
- y_out holds its last value from run completion until the next run overwrites each element in its BIAS cycle.
- Mid-run, y_out holds a mix of old and new elements. It is valid only while done=1 or in IDLE after a completed run.

## Timing
- Reset values: state=IDLE, busy=0, done=0, y_out=0, acc=0, i=j=0.
- Reset asserted in any state aborts the run on that edge and restores the reset values. No done pulse is issued.
- Let start be sampled high on edge E0.
- busy is high from E0 until the edge after DONE.
- MAC occupies N_IN cycles per output; BIAS occupies 1 cycle per output.
- done is high in cycle N_OUT*(N_IN+1)+1 after E0. With defaults this is cycle 13, so the total latency is 13 cycles.
- start may be reasserted in the first IDLE cycle after DONE, giving back-to-back runs at N_OUT*(N_IN+1)+2 cycles per layer.
- rst and start high together: rst wins.

## Configuration
- DENSE_SAT_EN defined: in BIAS, r is saturated to the signed WIDTH range. Overflow yields 32'h7FFFFFFF; underflow yields 32'h80000000.
- DENSE_SAT_EN undefined: r is truncated to its low WIDTH bits (two's-complement wrap). There is no overflow detection.

## Test plan
- Basic run (defaults): x=[1.0, 2.0, −1.0], all w=0.5 (32'h00800000), b[0]=32'h01A1B251. Required: y[0]=32'h02A1B251, and done high exactly 13 cycles after the start edge.
- Overflow: x all 100.0 (32'h64000000), w all 1.0, b=0. With DENSE_SAT_EN, every y=32'h7FFFFFFF. Without it, every y=32'h2C000000.
- Truncation toward −inf: x[0]=32'hFFFFFFFF (−1 LSB), w[0][0]=0.5, all other x/w=0, b=0. Required: y[0]=32'hFFFFFFFF.
- Input isolation: change x_in/w_in/b_in and pulse start during busy. Required: results match the values captured at E0, there is no second run, and done pulses exactly once.
- Reset mid-run: assert rst in the 5th MAC cycle. Required: next cycle busy=0, done=0, y_out=0. A subsequent start gives correct results.
- Back-to-back: start in the IDLE cycle immediately after done, using the negative bias set (b[1]=32'hFCFA3A3D) with x=0. Required: y[1]=32'hFCFA3A3D, with the second done 14 cycles after the first.
